// File: rtl/abcd_uart_tx_if.sv
// Store/load bus between the control unit and the 0xABCD serial peripheral.
// The control unit is the master; the peripheral is the slave.
interface abcd_uart_tx_if;
  logic        wr_en;
  logic [7:0]  wdata;
  logic        rd_en;
  logic [31:0] rdata;
  logic        stall;

  modport master (
    output wr_en,
    output wdata,
    output rd_en,
    input  rdata,
    input  stall
  );

  modport slave (
    input  wr_en,
    input  wdata,
    input  rd_en,
    output rdata,
    output stall
  );
endinterface

// File: rtl/abcd_uart_tx.sv
// Memory-mapped 8N1 UART transmitter at 0xABCD: byte queue, status word,
// store stall while the queue is full, and a registered serial output.
module abcd_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8,
  parameter int CNT_W        = 4
) (
  input  logic         clk,
  input  logic         reset,
  abcd_uart_tx_if.slave bus,
  output logic         tx
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  logic [1:0]        state;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;

  logic full;
  logic empty;
  logic busy;
  logic accept;
  logic drop;
  logic bit_done;
  logic pop;

  // Queue status and handshake decisions, all from pre-edge state.
  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign busy     = (state != ST_IDLE);
  assign accept   = bus.wr_en & ~full;
  assign drop     = bus.wr_en &  full;
  assign bit_done = (baud == BAUD_LAST);

  // The head byte leaves the queue when a frame starts, either from IDLE
  // or straight out of the stop bit so consecutive frames have no gap.
  assign pop = ~empty & ((state == ST_IDLE) | ((state == ST_STOP) & bit_done));

  assign bus.stall = full;
  assign bus.rdata = {24'd0, overflow, busy, full, empty, 4'(count)};

  // NOTE: the byte storage has no reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= bus.wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // A dropped byte outranks a status read so the loss is never missed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (bus.rd_en) begin
      overflow <= 1'b0;
    end
  end

  // Frame sequencer; tx is registered so the line never glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift <= mem[rd_ptr];
            baud  <= '0;
            tx    <= 1'b0;
            state <= ST_START;
          end
        end

        ST_START: begin
          if (bit_done) begin
            baud    <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= ST_DATA;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end

        ST_DATA: begin
          if (bit_done) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[bit_idx + 3'd1];
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end

        ST_STOP: begin
          if (bit_done) begin
            baud <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              tx    <= 1'b0;
              state <= ST_START;
            end else begin
              tx    <= 1'b1;
              state <= ST_IDLE;
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end

        default: begin
          tx    <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
